pipe_stage_elastic: RTL and testbench

//  Parametrised elastic pipeline-stage register; replaces fixed per-stage registers (IF/ID, ID/EX, ...).

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_slot.sv | 35 +++
 rtl/pipe_stage_elastic.sv | 146 ++++++++++++++
 tb/tb_pipe_stage_elastic.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: occupancy states and the bubble control value.
// Hazard and forwarding logic reuses these when inspecting occ_o.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    // Replicated across the control field width wherever a bubble is formed.
    localparam logic BUBBLE_CTRL = 1'b0;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline-stage entry: control + payload register with a valid bit.
// Clear squashes the entry into a bubble but leaves the payload untouched.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              ld_i,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [DATA_W-1:0] data_d,
    output logic              vld_q,
    output logic [CTRL_W-1:0] ctrl_q,
    output logic [DATA_W-1:0] data_q
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q  <= 1'b0;
            ctrl_q <= {CTRL_W{BUBBLE_CTRL}};
            data_q <= '0;
        end else if (clr_i) begin
            vld_q  <= 1'b0;
            ctrl_q <= {CTRL_W{BUBBLE_CTRL}};
        end else if (ld_i) begin
            vld_q  <= 1'b1;
            ctrl_q <= ctrl_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register with valid/ready handshake and sync flush.
// SKID=1 adds an overflow slot so in_ready_o comes straight from a flop.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned SKID   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occ_o
);

    logic              accept;
    logic              emit;
    logic              main_ld;
    logic              main_clr;
    logic              main_vld;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl_d;
    logic [DATA_W-1:0] main_data_d;

    assign accept = in_valid_i & in_ready_o;
    assign emit   = out_valid_o & out_ready_i;

    // Main slot always drives the outputs.
    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (main_clr),
        .ld_i   (main_ld),
        .ctrl_d (main_ctrl_d),
        .data_d (main_data_d),
        .vld_q  (main_vld),
        .ctrl_q (main_ctrl),
        .data_q (main_data)
    );

    assign out_valid_o = main_vld;
    assign out_ctrl_o  = main_vld ? main_ctrl : {CTRL_W{BUBBLE_CTRL}};
    assign out_data_o  = main_data;

    if (SKID != 0) begin : g_skid
        pipe_state_e       state_q;
        pipe_state_e       state_d;
        logic              ready_q;
        logic              main_from_skid;
        logic              skid_ld;
        logic              skid_clr;
        logic              skid_vld;
        logic [CTRL_W-1:0] skid_ctrl;
        logic [DATA_W-1:0] skid_data;

        pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .clr_i  (skid_clr),
            .ld_i   (skid_ld),
            .ctrl_d (in_ctrl_i),
            .data_d (in_data_i),
            .vld_q  (skid_vld),
            .ctrl_q (skid_ctrl),
            .data_q (skid_data)
        );

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q <= EMPTY;
                ready_q <= 1'b0;
            end else begin
                state_q <= state_d;
                ready_q <= (state_d != TWO);
            end
        end

        // Flush overrides every accept/emit transition.
        always_comb begin
            state_d        = state_q;
            main_ld        = 1'b0;
            main_clr       = 1'b0;
            main_from_skid = 1'b0;
            skid_ld        = 1'b0;
            skid_clr       = 1'b0;
            if (flush_i) begin
                state_d  = EMPTY;
                main_clr = 1'b1;
                skid_clr = 1'b1;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (accept) begin
                            main_ld = 1'b1;
                            state_d = ONE;
                        end
                    end
                    ONE: begin
                        if (accept && emit) begin
                            main_ld = 1'b1;
                        end else if (accept) begin
                            skid_ld = 1'b1;
                            state_d = TWO;
                        end else if (emit) begin
                            main_clr = 1'b1;
                            state_d  = EMPTY;
                        end
                    end
                    TWO: begin
                        if (emit) begin
                            main_ld        = 1'b1;
                            main_from_skid = 1'b1;
                            skid_clr       = 1'b1;
                            state_d        = ONE;
                        end
                    end
                    default: state_d = EMPTY;
                endcase
            end
        end

        assign main_ctrl_d = main_from_skid ? skid_ctrl : in_ctrl_i;
        assign main_data_d = main_from_skid ? skid_data : in_data_i;
        assign in_ready_o  = ready_q;
        // Skid is only ever occupied on top of an occupied main slot.
        assign occ_o       = {skid_vld, main_vld & ~skid_vld};
    end else begin : g_single
        // Accept and emit in one cycle simply replaces the slot contents.
        assign in_ready_o  = ~rst_i & (~main_vld | out_ready_i);
        assign main_ld     = accept & ~flush_i;
        assign main_clr    = flush_i | (emit & ~accept);
        assign main_ctrl_d = in_ctrl_i;
        assign main_data_d = in_data_i;
        assign occ_o       = {1'b0, main_vld};
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Drives a SKID=0 and a SKID=1 stage with identical inputs and scoreboards each
// against a queue model of the beats the stage currently holds.
module tb_pipe_stage_elastic;

    localparam int CW = 8;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush     [2];
    logic          in_valid  [2];
    logic          in_ready  [2];
    logic [CW-1:0] in_ctrl   [2];
    logic [DW-1:0] in_data   [2];
    logic          out_valid [2];
    logic          out_ready [2];
    logic [CW-1:0] out_ctrl  [2];
    logic [DW-1:0] out_data  [2];
    logic [1:0]    occ       [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [CW+DW-1:0] q[$];

        pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .SKID(g)) dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .flush_i     (flush[g]),
            .in_valid_i  (in_valid[g]),
            .in_ready_o  (in_ready[g]),
            .in_ctrl_i   (in_ctrl[g]),
            .in_data_i   (in_data[g]),
            .out_valid_o (out_valid[g]),
            .out_ready_i (out_ready[g]),
            .out_ctrl_o  (out_ctrl[g]),
            .out_data_o  (out_data[g]),
            .occ_o       (occ[g])
        );

        // Monitor: sample mid-cycle, compare against the held-beat queue, then
        // apply this cycle's emit, flush and accept to the queue.
        always @(negedge clk) begin
            logic exp_rdy;
            if (rst) begin
                chk($sformatf("s%0d rst valid", g), DW'(out_valid[g]), 0);
                chk($sformatf("s%0d rst ctrl", g), DW'(out_ctrl[g]), 0);
                chk($sformatf("s%0d rst occ", g), DW'(occ[g]), 0);
                chk($sformatf("s%0d rst ready", g), DW'(in_ready[g]), 0);
                q.delete();
            end else begin
                exp_rdy = (g == 1) ? (q.size() < 2) : (q.size() == 0 || out_ready[g]);
                chk($sformatf("s%0d valid", g), DW'(out_valid[g]), DW'(q.size() != 0));
                chk($sformatf("s%0d occ", g), DW'(occ[g]), DW'(q.size()));
                chk($sformatf("s%0d ready", g), DW'(in_ready[g]), DW'(exp_rdy));
                if (q.size() != 0) begin
                    chk($sformatf("s%0d ctrl", g), DW'(out_ctrl[g]), DW'(q[0][CW+DW-1:DW]));
                    chk($sformatf("s%0d data", g), out_data[g], q[0][DW-1:0]);
                    if (out_ready[g]) void'(q.pop_front());
                end else begin
                    chk($sformatf("s%0d bubble ctrl", g), DW'(out_ctrl[g]), 0);
                end
                if (flush[g]) q.delete();
                else if (in_valid[g] && exp_rdy) q.push_back({in_ctrl[g], in_data[g]});
            end
        end
    end

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input logic r, input logic f);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            in_valid[k]  = v;
            in_ctrl[k]   = c;
            in_data[k]   = d;
            out_ready[k] = r;
            flush[k]     = f;
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0; in_ctrl[k] = '0; in_data[k] = '0;
            out_ready[k] = 1'b0; flush[k] = 1'b0;
        end
        // Reset held three cycles, released shortly before a rising edge.
        repeat (3) @(posedge clk);
        #8 rst = 1'b0;

        // Streaming with downstream always ready.
        for (int i = 0; i < 10; i++) drive(1'b1, CW'(8'h81 + i), DW'(8'h11 + i), 1'b1, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b0);

        // Backpressure: fill, hold, then drain.
        drive(1'b1, 8'h01, 64'hA1, 1'b0, 1'b0);
        drive(1'b1, 8'h02, 64'hA2, 1'b0, 1'b0);
        repeat (3) drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (3) drive(1'b0, '0, '0, 1'b1, 1'b0);

        // Flush while full, with a beat offered in the flush cycle.
        drive(1'b1, 8'h03, 64'hB1, 1'b0, 1'b0);
        drive(1'b1, 8'h04, 64'hB2, 1'b0, 1'b0);
        drive(1'b1, 8'h05, 64'hB3, 1'b0, 1'b1);
        repeat (2) drive(1'b0, '0, '0, 1'b1, 1'b0);

        // Downstream ready toggling while a burst streams in.
        for (int i = 0; i < 4; i++) drive(1'b1, CW'(8'h41 + i), DW'(8'hC1 + i), (i % 2) == 0, 1'b0);
        repeat (4) drive(1'b0, '0, '0, 1'b1, 1'b0);

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 1500; i++)
            drive($urandom_range(0, 9) < 7, CW'($urandom), {$urandom, $urandom},
                  $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
        repeat (4) drive(1'b0, '0, '0, 1'b1, 1'b0);

        // Asynchronous reset while the skid stage is full.
        drive(1'b1, 8'h06, 64'hE1, 1'b0, 1'b0);
        drive(1'b1, 8'h07, 64'hE2, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #1;
        chk("s1 full before reset", DW'(occ[1]), 2);
        rst = 1'b1;
        #1;
        chk("s1 async valid drop", DW'(out_valid[1]), 0);
        chk("s0 async valid drop", DW'(out_valid[0]), 0);
        chk("s1 async occ drop", DW'(occ[1]), 0);
        repeat (2) @(posedge clk);
        @(posedge clk);
        #8 rst = 1'b0;
        drive(1'b1, 8'h08, 64'hD1, 1'b1, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        #1;
        chk("s1 first after reset", out_data[1], 64'hD1);
        chk("s0 first after reset", out_data[0], 64'hD1);
        repeat (3) drive(1'b0, '0, '0, 1'b1, 1'b0);

        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
